// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter: display prefetch (high priority) vs pixel writer on one single-port SRAM.
// Optional writer starvation guard enabled by defining FRAME_MEM_ARB_WR_STARVE_GUARD_EN.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned FRAME_WORDS = 248848,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MAX_WAIT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_frame_i,
  input  logic              pix_rd_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              underflow_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int unsigned FC_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [FC_W-1:0]   fetch_cnt_q;
  logic [FC_W-1:0]   fetch_base;
  logic [RD_LAT-1:0] infl_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wp_q;
  logic [PTR_W-1:0]  fifo_rp_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [CR_W-1:0]   credits;
  logic              disp_req;
  logic              force_wr;
  logic              rd_issue;
  logic              wr_xfer;
  logic              last_fetch;
  logic              push;
  logic              pop;

`ifdef FRAME_MEM_ARB_WR_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  // Grant and memory command; start_frame_i acts as an implicit flush, so credits are free that cycle
  always_comb begin
    credits = CR_W'(fifo_cnt_q);
    for (int i = 0; i < int'(RD_LAT); i++) begin
      credits = credits + CR_W'(infl_q[i]);
    end
    disp_req = (start_frame_i || state_q == FETCH) &&
               (start_frame_i || credits < CR_W'(FIFO_DEPTH));
`ifdef FRAME_MEM_ARB_WR_STARVE_GUARD_EN
    force_wr = (wait_q == WAIT_W'(MAX_WAIT));
`else
    force_wr = 1'b0;
`endif
    rd_issue    = disp_req && !force_wr;
    wr_ready_o  = !rd_issue;
    wr_xfer     = wr_valid_i && !rd_issue;
    rd_addr     = start_frame_i ? ADDR_W'(BASE_ADDR) : rd_ptr_q;
    fetch_base  = start_frame_i ? '0 : fetch_cnt_q;
    last_fetch  = rd_issue && (fetch_base + FC_W'(1) == FC_W'(FRAME_WORDS));
    push        = infl_q[RD_LAT-1] && !start_frame_i;
    pop         = pix_rd_i && (fifo_cnt_q != '0) && !start_frame_i;
    mem_req_o   = rd_issue || wr_xfer;
    mem_we_o    = wr_xfer;
    mem_addr_o  = rd_issue ? rd_addr : (wr_xfer ? wr_addr_i : '0);
    mem_wdata_o = wr_xfer ? wr_data_i : '0;
  end

  // Control state, in-flight pipe, FIFO pointers and scanout outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_o      <= 1'b0;
      rd_ptr_q    <= ADDR_W'(BASE_ADDR);
      fetch_cnt_q <= '0;
      infl_q      <= '0;
      fifo_wp_q   <= '0;
      fifo_rp_q   <= '0;
      fifo_cnt_q  <= '0;
      pix_data_o  <= '0;
      underflow_o <= 1'b0;
    end else begin
      if (start_frame_i || state_q == FETCH) begin
        state_q <= last_fetch ? DRAIN : FETCH;
        busy_o  <= 1'b1;
      end else if (state_q == DRAIN && infl_q == '0) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end

      rd_ptr_q    <= rd_addr + ADDR_W'(rd_issue);
      fetch_cnt_q <= fetch_base + FC_W'(rd_issue);

      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        infl_q[i] <= start_frame_i ? 1'b0 : infl_q[i-1];
      end
      infl_q[0] <= rd_issue;

      if (start_frame_i) begin
        fifo_wp_q  <= '0;
        fifo_rp_q  <= '0;
        fifo_cnt_q <= '0;
      end else begin
        fifo_wp_q  <= fifo_wp_q + PTR_W'(push);
        fifo_rp_q  <= fifo_rp_q + PTR_W'(pop);
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      if (pix_rd_i) begin
        pix_data_o <= pop ? fifo_mem[fifo_rp_q] : '0;
      end

      if (start_frame_i) begin
        underflow_o <= 1'b0;
      end else if (pix_rd_i && fifo_cnt_q == '0) begin
        underflow_o <= 1'b1;
      end
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wp_q] <= mem_rdata_i;
    end
  end

`ifdef FRAME_MEM_ARB_WR_STARVE_GUARD_EN
  // Writer wait counter; a full count steals one slot from the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (force_wr || wr_xfer) begin
      wait_q <= '0;
    end else if (wr_valid_i && !wr_ready_o) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end
`endif

endmodule
